// File: rtl/gate_op_arbiter_pkg.sv
// gate_op_arbiter_pkg
//   Shared definitions for the gate-op arbiter slice:
//   - opcode encodings OP_AND..OP_XNOR and OP_ILLEGAL
//   - FSM state encoding (S_IDLE / S_EXEC / S_RESP)
//   Imported by gate_op_unit and gate_op_arbiter.
package gate_op_arbiter_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gate_op_unit.sv
// gate_op_unit
//   Purely combinational bitwise logic unit shared by all requesters.
//   Ports:
//     op  in  3  opcode (see gate_op_arbiter_pkg)
//     a   in  W  operand A
//     b   in  W  operand B (unused for NOT)
//     y   out W  result; zero for the illegal opcode
//     err out 1  high for the illegal opcode
module gate_op_unit
  import gate_op_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: begin
        y   = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter
//   Round-robin arbiter in front of one registered logic unit. One op is in
//   flight at a time: IDLE picks a requester and captures its operands, EXEC
//   computes and registers the result, RESP holds it until res_ready.
//   Handshake: a result transfers on a rising edge where res_valid && res_ready;
//   res_valid and the result fields stay stable until then, and res_ready is
//   ignored while res_valid is low. Requests are held until the matching gnt
//   bit; gnt is a one-cycle pulse meaning the operands were captured.
//   Ports:
//     clk, rst_n         clock, synchronous active-low reset
//     req[N]             per-requester request
//     op_in[3N]          opcode slices, slice i = [3i+2:3i]
//     a_in/b_in[WN]      operand slices, slice i = [Wi+W-1:Wi]
//     gnt[N]             one-hot grant pulse
//     busy               high in EXEC and RESP
//     res_valid/ready    result handshake
//     res_data/id/err    result, owner id, illegal-opcode flag
//     op_count[16]       only with GATE_OP_ARBITER_STATS_EN: saturating count
//                        of completed result handshakes
//   IDW must equal clog2(N). All outputs are registered.
module gate_op_arbiter
  import gate_op_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [3*N-1:0]   op_in,
  input  logic [W*N-1:0]   a_in,
  input  logic [W*N-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [IDW-1:0]   res_id,
  output logic             res_err
`ifdef GATE_OP_ARBITER_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [N-1:0]   gnt_n;
  logic [2:0]     op_q, op_n;
  logic [W-1:0]   a_q, a_n, b_q, b_n;
  logic [IDW-1:0] id_q, id_n;
  logic           valid_n, err_n;
  logic [W-1:0]   data_n;
  logic [IDW-1:0] rid_n;

  logic           found;
  logic [IDW-1:0] winner;
  logic [W-1:0]   unit_y;
  logic           unit_err;

  gate_op_unit #(.W(W)) u_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (unit_y),
    .err (unit_err)
  );

  // First set request at or above rr_ptr, wrapping at N.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    gnt_n    = '0;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    id_n     = id_q;
    valid_n  = res_valid;
    data_n   = res_data;
    rid_n    = res_id;
    err_n    = res_err;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_n   = N'(1) << winner;
          op_n    = op_in[3*winner +: 3];
          a_n     = a_in[W*winner +: W];
          b_n     = b_in[W*winner +: W];
          id_n    = winner;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        valid_n = 1'b1;
        data_n  = unit_y;
        err_n   = unit_err;
        rid_n   = id_q;
        state_n = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          valid_n  = 1'b0;
          // Next search starts just after the requester that was served.
          rr_ptr_n = (res_id == IDW'(N - 1)) ? '0 : res_id + IDW'(1);
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      gnt       <= gnt_n;
      op_q      <= op_n;
      a_q       <= a_n;
      b_q       <= b_n;
      id_q      <= id_n;
      res_valid <= valid_n;
      res_data  <= data_n;
      res_id    <= rid_n;
      res_err   <= err_n;
    end
  end

  // state is a register, so busy carries no combinational input path.
  assign busy = (state != S_IDLE);

`ifdef GATE_OP_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (res_valid && res_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
